// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the opcode/funct constants, the ALU select codes, the datapath
// mux encodings, the 4-bit control state enum, and the operation class
// that the control FSM hands to the ALU decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h02;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;
  localparam logic [1:0] SRCA_B  = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXE   = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EXE   = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // What kind of ALU operation the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_BR  = 2'd3
  } alu_cls_t;

endpackage

// File: rtl/mips_mc_control_alu_decoder.sv
// alu_decoder: combinational ALU select decode.
// Ports:
//   opcode, funct  instruction fields
//   cls            operation class from the control FSM (alu_cls_t)
//   alu_sel        ALU select code
//   ext_sel        immediate extension (0 sign, 1 zero)
//   funct_valid    R-type (or mul) funct is one the ALU implements
module alu_decoder
  import mips_pkg::*;
#(
  parameter bit SUPPORT_MUL = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] cls,
  output logic [3:0] alu_sel,
  output logic       ext_sel,
  output logic       funct_valid
);

  always_comb begin
    alu_sel     = ALU_ADD;
    ext_sel     = 1'b0;
    funct_valid = 1'b0;
    case (cls)
      CLS_R: begin
        if (opcode == OP_MUL) begin
          if (SUPPORT_MUL && funct == F_MUL) begin
            alu_sel     = ALU_MUL;
            funct_valid = 1'b1;
          end
        end else begin
          funct_valid = 1'b1;
          case (funct)
            F_ADD:   alu_sel = ALU_ADD;
            F_SUB:   alu_sel = ALU_SUB;
            F_AND:   alu_sel = ALU_AND;
            F_OR:    alu_sel = ALU_OR;
            F_NOR:   alu_sel = ALU_NOR;
            F_SLT:   alu_sel = ALU_SLT;
            F_SLL:   alu_sel = ALU_SLL;
            F_SRL:   alu_sel = ALU_SRL;
            default: funct_valid = 1'b0;
          endcase
        end
      end
      CLS_I: begin
        case (opcode)
          OP_SLTI: alu_sel = ALU_SLT;
          OP_ANDI: begin alu_sel = ALU_AND; ext_sel = 1'b1; end
          OP_ORI:  begin alu_sel = ALU_OR;  ext_sel = 1'b1; end
          OP_LUI:  alu_sel = ALU_LUI;
          default: alu_sel = ALU_ADD;
        endcase
      end
      CLS_BR:  alu_sel = ALU_SUB;
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle control FSM for the 32-bit MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives the ALU select,
// datapath mux selects and write enables, and stalls FETCH, MEM_RD and
// MEM_WR until mem_ready.
// Ports:
//   clk, rst (sync, active-high), opcode, funct, zero (ALU Z), mem_ready
//   pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, ext_sel, pc_src, alu_sel, state
module mips_mc_control
  import mips_pkg::*;
#(
  parameter bit SUPPORT_MUL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic [3:0] alu_sel,
  output logic [3:0] state
);

  state_t   state_q, state_d;
  alu_cls_t cls;
  logic     funct_valid;
  logic     is_shift;

  alu_decoder #(.SUPPORT_MUL(SUPPORT_MUL)) u_alu_dec (
    .opcode      (opcode),
    .funct       (funct),
    .cls         (cls),
    .alu_sel     (alu_sel),
    .ext_sel     (ext_sel),
    .funct_valid (funct_valid)
  );

  // Shifts take the value from rt (B reg) and the amount from imm[10:6].
  assign is_shift = (opcode == OP_RTYPE) && ((funct == F_SLL) || (funct == F_SRL));
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cls        = CLS_ADD;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SRCB_BRIMM;
        case (opcode)
          OP_LW, OP_SW:                          state_d = S_MEM_ADR;
          OP_RTYPE:                              state_d = S_R_EXE;
          OP_MUL:                                state_d = SUPPORT_MUL ? S_R_EXE : S_FETCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXE;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          OP_J:                                  state_d = S_JUMP;
          default:                               state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXE: begin
        cls       = CLS_R;
        alu_src_a = is_shift ? SRCA_B : SRCA_A;
        alu_src_b = is_shift ? SRCB_IMM : SRCB_B;
        // An unknown funct is dropped without writeback.
        state_d   = funct_valid ? S_R_WB : S_FETCH;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXE: begin
        cls       = CLS_I;
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        cls       = CLS_BR;
        alu_src_a = SRCA_A;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset abandons whatever is in flight: nothing is written or requested.
    if (rst) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

endmodule
